// File: rtl/mmcm_seq_pkg.sv
// rtl/mmcm_seq_pkg.sv - state encoding and default timing for the MMCM reset sequencer
package mmcm_seq_pkg;

    localparam logic [2:0] ST_ASSERT_RST_ENC = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK_ENC  = 3'd1;
    localparam logic [2:0] ST_STABLE_ENC     = 3'd2;
    localparam logic [2:0] ST_RUN_ENC        = 3'd3;
    localparam logic [2:0] ST_FAULT_ENC      = 3'd4;

    typedef enum logic [2:0] {
        ST_ASSERT_RST = ST_ASSERT_RST_ENC,
        ST_WAIT_LOCK  = ST_WAIT_LOCK_ENC,
        ST_STABLE     = ST_STABLE_ENC,
        ST_RUN        = ST_RUN_ENC,
        ST_FAULT      = ST_FAULT_ENC
    } state_t;

    // Defaults sized for a 100 MHz reference clock
    localparam int DEF_RST_HOLD_CYCLES     = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 10000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 256;
    localparam int DEF_MAX_RETRIES         = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-stage single-bit synchronizer for asynchronous status inputs
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic stage1;
    (* ASYNC_REG = "TRUE" *) logic stage2;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage1 <= 1'b0;
            stage2 <= 1'b0;
        end else begin
            stage1 <= d;
            stage2 <= stage1;
        end
    end

    assign q = stage2;

endmodule

// File: rtl/mmcm_reset_sequencer.sv
// rtl/mmcm_reset_sequencer.sv - MMCM reset pulse, lock wait with retries, lock qualification and system reset release
module mmcm_reset_sequencer
    import mmcm_seq_pkg::*;
#(
    parameter int TCQ                 = 1,
    parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       mmcm_locked,
    input  logic       restart_req,
    output logic       mmcm_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [7:0] retry_cnt,
    output logic [7:0] lock_lost_cnt,
    output logic [2:0] state_o
);

    localparam int TW = $clog2(max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)) + 1;

    // Registers carry no modelled delay; TCQ only takes part in the parameter sanity check
    if (TCQ < 0 || RST_HOLD_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
        LOCK_STABLE_CYCLES < 1 || MAX_RETRIES < 1 || MAX_RETRIES > 255) begin : g_bad_param
        $error("mmcm_reset_sequencer: parameter out of range");
    end

    state_t        state;
    state_t        nxt_state;
    logic [TW-1:0] timer;
    logic [TW-1:0] nxt_timer;
    logic [7:0]    nxt_retry;
    logic [7:0]    nxt_lost;
    logic [8:0]    retry_inc;
    logic          locked_s;

    sync_2ff u_lock_sync (
        .clk   (clk_in),
        .reset (reset),
        .d     (mmcm_locked),
        .q     (locked_s)
    );

    assign retry_inc = {1'b0, retry_cnt} + 9'd1;

    always_comb begin
        nxt_state = state;
        nxt_timer = timer + 1'b1;
        nxt_retry = retry_cnt;
        nxt_lost  = lock_lost_cnt;
        if (restart_req) begin
            nxt_state = ST_ASSERT_RST;
            nxt_timer = '0;
            nxt_retry = '0;
        end else begin
            case (state)
                ST_ASSERT_RST: begin
                    if (timer == TW'(RST_HOLD_CYCLES - 1)) begin
                        nxt_state = ST_WAIT_LOCK;
                        nxt_timer = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still counts as a lock
                    if (locked_s) begin
                        nxt_state = ST_STABLE;
                        nxt_timer = '0;
                    end else if (timer == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        nxt_retry = retry_inc[7:0];
                        nxt_timer = '0;
                        nxt_state = (retry_inc < 9'(MAX_RETRIES)) ? ST_ASSERT_RST : ST_FAULT;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        nxt_state = ST_WAIT_LOCK;
                        nxt_timer = '0;
                    end else if (timer == TW'(LOCK_STABLE_CYCLES - 1)) begin
                        nxt_state = ST_RUN;
                        nxt_timer = '0;
                        nxt_retry = '0;
                    end
                end
                ST_RUN: begin
                    nxt_timer = '0;
                    if (!locked_s) begin
                        nxt_state = ST_ASSERT_RST;
                        nxt_lost  = (lock_lost_cnt == 8'hFF) ? lock_lost_cnt : lock_lost_cnt + 8'd1;
                    end
                end
                ST_FAULT: begin
                    nxt_timer = '0;
                end
                default: begin
                    nxt_state = ST_ASSERT_RST;
                    nxt_timer = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they change in the same cycle the state is entered
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state         <= ST_ASSERT_RST;
            timer         <= '0;
            retry_cnt     <= '0;
            lock_lost_cnt <= '0;
            mmcm_rst      <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
            state_o       <= ST_ASSERT_RST_ENC;
        end else begin
            state         <= nxt_state;
            timer         <= nxt_timer;
            retry_cnt     <= nxt_retry;
            lock_lost_cnt <= nxt_lost;
            mmcm_rst      <= (nxt_state == ST_ASSERT_RST) || (nxt_state == ST_FAULT);
            sys_rst       <= (nxt_state != ST_RUN);
            ready         <= (nxt_state == ST_RUN);
            fault         <= (nxt_state == ST_FAULT);
            state_o       <= nxt_state;
        end
    end

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// tb/tb_mmcm_reset_sequencer.sv - self-checking bench for mmcm_reset_sequencer
module tb_mmcm_reset_sequencer;

    localparam int RST_HOLD    = 4;
    localparam int TIMEOUT     = 20;
    localparam int STABLE      = 8;
    localparam int MAX_RETRIES = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mmcm_locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       mmcm_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [7:0] retry_cnt;
    logic [7:0] lock_lost_cnt;
    logic [2:0] state_o;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: phase numbers follow the published state_o codes; m_age = cycles elapsed in the phase
    int m_phase = 0;
    int m_age   = 0;
    int m_retry = 0;
    int m_lost  = 0;
    int cnum    = 0;
    bit lk_q[$];
    bit ls;

    mmcm_reset_sequencer #(
        .TCQ                 (1),
        .RST_HOLD_CYCLES     (RST_HOLD),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .LOCK_STABLE_CYCLES  (STABLE),
        .MAX_RETRIES         (MAX_RETRIES)
    ) dut (
        .clk_in        (clk),
        .reset         (reset),
        .mmcm_locked   (mmcm_locked),
        .restart_req   (restart_req),
        .mmcm_rst      (mmcm_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt),
        .lock_lost_cnt (lock_lost_cnt),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cnum, $time);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_phase = 0; m_age = 0; m_retry = 0; m_lost = 0; cnum = 0;
                lk_q.delete();
                lk_q.push_back(1'b0);
                lk_q.push_back(1'b0);
            end else begin
                cnum++;
                ls = lk_q.pop_front();
                lk_q.push_back(mmcm_locked);
                if (restart_req) begin
                    m_phase = 0; m_age = 0; m_retry = 0;
                end else if (m_phase == 0) begin
                    m_age++;
                    if (m_age == RST_HOLD) begin m_phase = 1; m_age = 0; end
                end else if (m_phase == 1) begin
                    if (ls) begin
                        m_phase = 2; m_age = 0;
                    end else begin
                        m_age++;
                        if (m_age == TIMEOUT) begin
                            m_retry++;
                            m_phase = (m_retry < MAX_RETRIES) ? 0 : 4;
                            m_age = 0;
                        end
                    end
                end else if (m_phase == 2) begin
                    if (!ls) begin
                        m_phase = 1; m_age = 0;
                    end else begin
                        m_age++;
                        if (m_age == STABLE) begin m_phase = 3; m_age = 0; m_retry = 0; end
                    end
                end else if (m_phase == 3) begin
                    if (!ls) begin
                        m_phase = 0; m_age = 0;
                        if (m_lost < 255) m_lost++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("mmcm_rst", int'(mmcm_rst), int'(m_phase == 0 || m_phase == 4));
            chk("sys_rst", int'(sys_rst), int'(m_phase != 3));
            chk("ready", int'(ready), int'(m_phase == 3));
            chk("fault", int'(fault), int'(m_phase == 4));
            chk("retry_cnt", int'(retry_cnt), m_retry);
            chk("lock_lost_cnt", int'(lock_lost_cnt), m_lost);
            chk("state_o", int'(state_o), m_phase);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int c);
        int guard = 0;
        while (cnum < c && guard < 2000) begin step(); guard++; end
        if (cnum != c) begin
            n_chk++;
            $display("FAIL go_to: reached cycle %0d, expected %0d", cnum, c);
        end
    endtask

    task automatic at(input int c);
        go_to(c);
        @(negedge clk);
    endtask

    task automatic wait_ready(input logic lvl);
        int k = 0;
        while (ready !== lvl && k < 200) begin step(); k++; end
        n_chk++;
        if (ready === lvl) n_pass++;
        else $display("FAIL wait_ready: ready=%0b, expected %0b after %0d cycles", ready, lvl, k);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mmcm_locked = 1'b0;
        restart_req = 1'b0;
        repeat (3) step();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        // Normal bring-up, lock at cycle 10
        at(3);   chk("s1_mmcm_rst_c3", mmcm_rst, 1);
        at(4);   chk("s1_mmcm_rst_c4", mmcm_rst, 0); chk("s1_state_c4", state_o, 1);
        go_to(10); mmcm_locked = 1'b1;
        at(12);  chk("s1_state_c12", state_o, 1);
        at(13);  chk("s1_state_c13", state_o, 2);
        at(20);  chk("s1_ready_c20", ready, 0); chk("s1_sys_rst_c20", sys_rst, 1);
        at(21);  chk("s1_ready_c21", ready, 1); chk("s1_sys_rst_c21", sys_rst, 0); chk("s1_retry_c21", retry_cnt, 0);

        // One-cycle loss of lock in RUN
        go_to(30); mmcm_locked = 1'b0;
        step();    mmcm_locked = 1'b1;
        at(32);  chk("s4_sys_rst_c32", sys_rst, 0);
        at(33);  chk("s4_sys_rst_c33", sys_rst, 1); chk("s4_lost_c33", lock_lost_cnt, 1); chk("s4_mmcm_c33", mmcm_rst, 1);
        at(36);  chk("s4_mmcm_c36", mmcm_rst, 1);
        at(37);  chk("s4_mmcm_c37", mmcm_rst, 0);
        at(45);  chk("s4_ready_c45", ready, 0);
        at(46);  chk("s4_ready_c46", ready, 1);

        // Permanent loss: two timeouts then FAULT
        go_to(50); mmcm_locked = 1'b0;
        at(53);  chk("s2_lost_c53", lock_lost_cnt, 2);
        at(76);  chk("s2_state_c76", state_o, 1); chk("s2_retry_c76", retry_cnt, 0);
        at(77);  chk("s2_state_c77", state_o, 0); chk("s2_retry_c77", retry_cnt, 1);
        at(100); chk("s2_fault_c100", fault, 0);
        at(101); chk("s2_fault_c101", fault, 1); chk("s2_mmcm_c101", mmcm_rst, 1);
                 chk("s2_retry_c101", retry_cnt, 2); chk("s2_state_c101", state_o, 4); chk("s2_ready_c101", ready, 0);
        at(104); chk("s2_fault_c104", fault, 1);

        // Restart out of FAULT keeps lock_lost_cnt
        go_to(105); restart_req = 1'b1;
        step();     restart_req = 1'b0;
        at(106); chk("s5_fault_c106", fault, 0); chk("s5_state_c106", state_o, 0);
                 chk("s5_retry_c106", retry_cnt, 0); chk("s5_lost_c106", lock_lost_cnt, 2); chk("s5_mmcm_c106", mmcm_rst, 1);

        // Restart collides with the timeout cycle
        go_to(129); restart_req = 1'b1;
        at(129); chk("s6_state_c129", state_o, 1);
        step();     restart_req = 1'b0;
        at(130); chk("s6_state_c130", state_o, 0); chk("s6_retry_c130", retry_cnt, 0);

        // Synced lock arrives exactly on the timeout cycle
        go_to(151); mmcm_locked = 1'b1;
        at(153); chk("lk_state_c153", state_o, 1);
        at(154); chk("lk_state_c154", state_o, 2); chk("lk_retry_c154", retry_cnt, 0);

        // Reset in the middle of STABLE
        go_to(157); reset = 1'b1;
        step();     reset = 1'b0;
        @(negedge clk);
        chk("rst_mmcm", mmcm_rst, 1); chk("rst_sys", sys_rst, 1); chk("rst_ready", ready, 0);
        chk("rst_fault", fault, 0); chk("rst_retry", retry_cnt, 0); chk("rst_lost", lock_lost_cnt, 0);
        chk("rst_state", state_o, 0);
        at(12);  chk("rb_ready_c12", ready, 0);
        at(13);  chk("rb_ready_c13", ready, 1);

        // Glitchy lock: high 5, low 1, then steady
        go_to(20);
        do_reset();
        go_to(10); mmcm_locked = 1'b1;
        go_to(15); mmcm_locked = 1'b0;
        go_to(16); mmcm_locked = 1'b1;
        at(17);  chk("s3_state_c17", state_o, 2);
        at(18);  chk("s3_state_c18", state_o, 1); chk("s3_retry_c18", retry_cnt, 0);
        at(19);  chk("s3_state_c19", state_o, 2);
        at(26);  chk("s3_ready_c26", ready, 0);
        at(27);  chk("s3_ready_c27", ready, 1); chk("s3_retry_c27", retry_cnt, 0);

        // Repeated losses drive lock_lost_cnt into saturation
        for (int i = 0; i < 257; i++) begin
            wait_ready(1'b1);
            mmcm_locked = 1'b0;
            step();
            mmcm_locked = 1'b1;
            wait_ready(1'b0);
        end
        wait_ready(1'b1);
        @(negedge clk);
        chk("sat_lost", lock_lost_cnt, 255);

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
